// File: rtl/burst_sched_pkg.sv
// burst_sched_pkg
//   Shared definitions for the burst write scheduler: the scheduler state
//   encoding and the default widths it has in common with the Avalon-MM
//   burst write master (burst_write_wf).
package burst_sched_pkg;

  localparam int SCHED_ADDRESS_WIDTH          = 32;
  localparam int SCHED_LENGTH_WIDTH           = 32;
  localparam int SCHED_BURST_COUNT            = 8;
  localparam int SCHED_BURST_WIDTH            = 4;
  localparam int SCHED_BYTE_ENABLE_WIDTH_LOG2 = 2;
  localparam int SCHED_USEDW_WIDTH            = 9;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/burst_size_calc.sv
// burst_size_calc
//   Combinational sizing of the next burst.
//   The legal limit is min(BURST_COUNT, remaining, room before the ring wrap).
//   If the FIFO holds at least that many words the full limit is issued;
//   otherwise, with flush high and a non-empty FIFO, whatever the FIFO holds
//   is issued; otherwise no burst is possible yet.
// Ports:
//   i_remaining   words still to write in this transfer
//   i_wrap_words  ring span in words (0 = no wrap)
//   i_offset      current word offset inside the ring
//   i_fifo_usedw  words available upstream
//   i_flush       permit a partial burst
//   o_burst_words size of the burst to issue
//   o_burst_ok    a burst of o_burst_words may be issued now
module burst_size_calc
  import burst_sched_pkg::*;
#(
  parameter int LENGTH_WIDTH = SCHED_LENGTH_WIDTH,
  parameter int USEDW_WIDTH  = SCHED_USEDW_WIDTH,
  parameter int BURST_COUNT  = SCHED_BURST_COUNT
) (
  input  logic [LENGTH_WIDTH-1:0] i_remaining,
  input  logic [LENGTH_WIDTH-1:0] i_wrap_words,
  input  logic [LENGTH_WIDTH-1:0] i_offset,
  input  logic [USEDW_WIDTH-1:0]  i_fifo_usedw,
  input  logic                    i_flush,
  output logic [LENGTH_WIDTH-1:0] o_burst_words,
  output logic                    o_burst_ok
);

  logic [LENGTH_WIDTH-1:0] w_burst_max;
  logic [LENGTH_WIDTH-1:0] w_wrap_room;
  logic [LENGTH_WIDTH-1:0] w_usedw;
  logic [LENGTH_WIDTH-1:0] w_limit;

  assign w_burst_max = LENGTH_WIDTH'(BURST_COUNT);
  assign w_wrap_room = i_wrap_words - i_offset;
  assign w_usedw     = LENGTH_WIDTH'(i_fifo_usedw);

  always_comb begin
    w_limit = w_burst_max;
    if (i_remaining < w_limit) begin
      w_limit = i_remaining;
    end
    // A zero ring span means a linear buffer: the wrap term drops out.
    if ((i_wrap_words != '0) && (w_wrap_room < w_limit)) begin
      w_limit = w_wrap_room;
    end

    o_burst_words = w_limit;
    o_burst_ok    = 1'b0;
    if (w_usedw >= w_limit) begin
      o_burst_ok = 1'b1;
    end else if (i_flush && (w_usedw != '0)) begin
      o_burst_words = w_usedw;
      o_burst_ok    = 1'b1;
    end
  end

endmodule

// File: rtl/burst_write_sched.sv
// burst_write_sched
//   Splits one multi-word capture transfer into legal bursts for the
//   burst write master and issues them one at a time through the writer's
//   ctrl_start/ctrl_busy handshake.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   go, stop, flush         start pulse, sticky abort request, partial-burst permit
//   cfg_baseaddress         ring base (byte address, word aligned), sampled on go
//   cfg_length              total words, sampled on go
//   cfg_wrap_words          ring span in words (0 = no wrap), sampled on go
//   fifo_usedw              words available upstream
//   wr_start/wr_baseaddress/wr_burstcount/wr_busy   writer control handshake
//   busy, done, aborted     transfer status
//   words_written           words committed in the current transfer
module burst_write_sched
  import burst_sched_pkg::*;
#(
  parameter int ADDRESS_WIDTH          = SCHED_ADDRESS_WIDTH,
  parameter int LENGTH_WIDTH           = SCHED_LENGTH_WIDTH,
  parameter int BURST_COUNT            = SCHED_BURST_COUNT,
  parameter int BURST_WIDTH            = SCHED_BURST_WIDTH,
  parameter int BYTE_ENABLE_WIDTH_LOG2 = SCHED_BYTE_ENABLE_WIDTH_LOG2,
  parameter int USEDW_WIDTH            = SCHED_USEDW_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     stop,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] cfg_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]  cfg_length,
  input  logic [LENGTH_WIDTH-1:0]  cfg_wrap_words,
  input  logic [USEDW_WIDTH-1:0]   fifo_usedw,
  output logic                     wr_start,
  output logic [ADDRESS_WIDTH-1:0] wr_baseaddress,
  output logic [BURST_WIDTH-1:0]   wr_burstcount,
  input  logic                     wr_busy,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [LENGTH_WIDTH-1:0]  words_written
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ALIGN_MASK =
    ADDRESS_WIDTH'((1 << BYTE_ENABLE_WIDTH_LOG2) - 1);

  sched_state_t             r_state,     w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_base,      w_base_next;
  logic [LENGTH_WIDTH-1:0]  r_wrap,      w_wrap_next;
  logic [LENGTH_WIDTH-1:0]  r_offset,    w_offset_next;
  logic [LENGTH_WIDTH-1:0]  r_remaining, w_remaining_next;
  logic [LENGTH_WIDTH-1:0]  r_n,         w_n_next;
  logic [ADDRESS_WIDTH-1:0] r_addr,      w_addr_next;
  logic [LENGTH_WIDTH-1:0]  r_words,     w_words_next;
  logic                     r_stop,      w_stop_next;
  logic                     r_busy,      w_busy_next;
  logic                     r_done,      w_done_next;
  logic                     r_aborted,   w_aborted_next;
  logic                     w_start;
  logic [LENGTH_WIDTH-1:0]  w_offset_sum;
  logic [LENGTH_WIDTH-1:0]  w_calc_n;
  logic                     w_calc_ok;

  burst_size_calc #(
    .LENGTH_WIDTH (LENGTH_WIDTH),
    .USEDW_WIDTH  (USEDW_WIDTH),
    .BURST_COUNT  (BURST_COUNT)
  ) u_size_calc (
    .i_remaining   (r_remaining),
    .i_wrap_words  (r_wrap),
    .i_offset      (r_offset),
    .i_fifo_usedw  (fifo_usedw),
    .i_flush       (flush),
    .o_burst_words (w_calc_n),
    .o_burst_ok    (w_calc_ok)
  );

  always_comb begin
    w_state_next     = r_state;
    w_base_next      = r_base;
    w_wrap_next      = r_wrap;
    w_offset_next    = r_offset;
    w_remaining_next = r_remaining;
    w_n_next         = r_n;
    w_addr_next      = r_addr;
    w_words_next     = r_words;
    // stop is sticky for the life of a transfer
    w_stop_next      = r_stop | stop;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_aborted_next   = r_aborted;
    w_start          = 1'b0;
    w_offset_sum     = r_offset + r_n;

    case (r_state)
      IDLE: begin
        w_stop_next = 1'b0;
        if (go) begin
          w_base_next      = cfg_baseaddress;
          w_wrap_next      = cfg_wrap_words;
          w_offset_next    = '0;
          w_remaining_next = cfg_length;
          w_words_next     = '0;
          w_aborted_next   = 1'b0;
          w_busy_next      = 1'b1;
          // a stop arriving together with go is kept for the new transfer
          w_stop_next      = stop;
          w_state_next     = (cfg_length == '0) ? FINISH : EVAL;
        end
      end
      EVAL: begin
        if (r_stop || stop) begin
          w_aborted_next = 1'b1;
          w_state_next   = FINISH;
        end else if (w_calc_ok) begin
          // Burst size and address are frozen here so they stay stable
          // through ISSUE and WAIT_ACK.
          w_n_next     = w_calc_n;
          w_addr_next  = r_base + (ADDRESS_WIDTH'(r_offset) << BYTE_ENABLE_WIDTH_LOG2);
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!wr_busy) begin
          w_start      = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (wr_busy) begin
          w_state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!wr_busy) begin
          w_words_next     = r_words + r_n;
          w_remaining_next = r_remaining - r_n;
          w_offset_next    = ((r_wrap != '0) && (w_offset_sum == r_wrap)) ? '0 : w_offset_sum;
          if (r_remaining == r_n) begin
            w_state_next = FINISH;
          end else if (r_stop || stop) begin
            w_aborted_next = 1'b1;
            w_state_next   = FINISH;
          end else begin
            w_state_next = EVAL;
          end
        end
      end
      FINISH: begin
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_stop_next  = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_wrap      <= '0;
      r_offset    <= '0;
      r_remaining <= '0;
      r_n         <= '0;
      r_addr      <= '0;
      r_words     <= '0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_base      <= w_base_next;
      r_wrap      <= w_wrap_next;
      r_offset    <= w_offset_next;
      r_remaining <= w_remaining_next;
      r_n         <= w_n_next;
      r_addr      <= w_addr_next;
      r_words     <= w_words_next;
      r_stop      <= w_stop_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_aborted   <= w_aborted_next;
    end
  end

  // The base address is used as-is, so it has to be word aligned.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == IDLE) && go) begin
      assert ((cfg_baseaddress & ADDR_ALIGN_MASK) == '0);
    end
  end

  assign wr_start       = w_start;
  assign wr_baseaddress = r_addr;
  assign wr_burstcount  = BURST_WIDTH'(r_n);
  assign busy           = r_busy;
  assign done           = r_done;
  assign aborted        = r_aborted;
  assign words_written  = r_words;

endmodule

// File: tb/tb_burst_write_sched.sv
module tb_burst_write_sched;

  localparam int AW = 32;
  localparam int LW = 32;
  localparam int BW = 4;
  localparam int UW = 9;
  localparam logic [AW-1:0] BASE = 32'h3800_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          stop = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] cfg_baseaddress = '0;
  logic [LW-1:0] cfg_length = '0;
  logic [LW-1:0] cfg_wrap_words = '0;
  logic [UW-1:0] fifo_usedw = '0;
  logic          wr_start;
  logic [AW-1:0] wr_baseaddress;
  logic [BW-1:0] wr_burstcount;
  logic          wr_busy = 1'b0;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+BW-1:0] exp_q[$];
  logic [AW+BW-1:0] mon_exp;
  int               wm_cnt = 0;
  logic             cap_aborted;
  logic             cap_busy;
  logic [LW-1:0]    cap_words;

  burst_write_sched #(
    .ADDRESS_WIDTH          (AW),
    .LENGTH_WIDTH           (LW),
    .BURST_COUNT            (8),
    .BURST_WIDTH            (BW),
    .BYTE_ENABLE_WIDTH_LOG2 (2),
    .USEDW_WIDTH            (UW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .go              (go),
    .stop            (stop),
    .flush           (flush),
    .cfg_baseaddress (cfg_baseaddress),
    .cfg_length      (cfg_length),
    .cfg_wrap_words  (cfg_wrap_words),
    .fifo_usedw      (fifo_usedw),
    .wr_start        (wr_start),
    .wr_baseaddress  (wr_baseaddress),
    .wr_burstcount   (wr_burstcount),
    .wr_busy         (wr_busy),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .words_written   (words_written)
  );

  always #5 clk = ~clk;

  // Writer model: busy rises the cycle after start and stays high 4 cycles.
  always @(posedge clk) begin
    if (reset) begin
      wr_busy <= 1'b0;
      wm_cnt  <= 0;
    end else if (wr_start) begin
      wr_busy <= 1'b1;
      wm_cnt  <= 3;
    end else if (wm_cnt != 0) begin
      wm_cnt <= wm_cnt - 1;
    end else begin
      wr_busy <= 1'b0;
    end
  end

  // Scoreboard: every issued burst is popped against the expected queue.
  always @(negedge clk) begin
    if (!reset && wr_start) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL burst_unexpected: got addr=0x%08h count=%0d, required no burst",
                 wr_baseaddress, wr_burstcount);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wr_baseaddress, wr_burstcount} !== mon_exp) begin
          n_fail++;
          $display("FAIL burst: got addr=0x%08h count=%0d, required addr=0x%08h count=%0d",
                   wr_baseaddress, wr_burstcount, mon_exp[AW+BW-1:BW], mon_exp[BW-1:0]);
        end else begin
          $display("burst addr=0x%08h count=%0d ok", wr_baseaddress, wr_burstcount);
        end
      end
    end
  end

  task automatic start_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input logic [LW-1:0] wrap);
    @(negedge clk);
    cfg_baseaddress = base;
    cfg_length      = len;
    cfg_wrap_words  = wrap;
    go              = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen        = 1'b1;
        cap_aborted = aborted;
        cap_busy    = busy;
        cap_words   = words_written;
      end
    end
  endtask

  task automatic wait_start(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (wr_start) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_start !== 1'b0) begin n_fail++; $display("FAIL reset_wr_start: got %b required 0", wr_start); end
    n_checks++; if (wr_baseaddress !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got 0x%08h required 0", wr_baseaddress); end
    n_checks++; if (wr_burstcount !== '0) begin n_fail++; $display("FAIL reset_wr_count: got %0d required 0", wr_burstcount); end
    n_checks++; if ({busy, done, aborted} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got busy/done/aborted=%b required 000", {busy, done, aborted}); end
    n_checks++; if (words_written !== '0) begin n_fail++; $display("FAIL reset_words: got %0d required 0", words_written); end
    $display("test_reset done");
    reset = 1'b0;
  endtask

  task automatic test_single_burst();
    bit seen;
    fifo_usedw = 9'd16;
    exp_q.push_back({BASE, 4'd8});
    start_xfer(BASE, 32'd8, 32'd0);
    n_checks++; if (wr_start !== 1'b0) begin n_fail++; $display("FAIL latency_eval: wr_start got %b required 0", wr_start); end
    @(negedge clk);
    n_checks++; if (wr_start !== 1'b1) begin n_fail++; $display("FAIL latency_issue: wr_start got %b required 1", wr_start); end
    wait_done(60, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL single_done: got no done required done"); end
    n_checks++; if (cap_words !== 32'd8 || cap_aborted !== 1'b0 || cap_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_status: got words=%0d aborted=%b busy=%b required 8 0 0", cap_words, cap_aborted, cap_busy); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d bursts left required 0", exp_q.size()); end
    $display("test_single_burst done");
  endtask

  task automatic test_split();
    bit seen;
    fifo_usedw = 9'd64;
    exp_q.push_back({BASE,            4'd8});
    exp_q.push_back({BASE + 32'h20,   4'd8});
    exp_q.push_back({BASE + 32'h40,   4'd4});
    start_xfer(BASE, 32'd20, 32'd0);
    wait_start(20, seen);
    // a second go while busy must be ignored
    cfg_baseaddress = 32'h0;
    cfg_length      = 32'd1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(120, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL split_done: got no done required done"); end
    n_checks++; if (cap_words !== 32'd20 || cap_aborted !== 1'b0) begin
      n_fail++; $display("FAIL split_status: got words=%0d aborted=%b required 20 0", cap_words, cap_aborted); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL split_missing: %0d bursts left required 0", exp_q.size()); end
    $display("test_split done");
  endtask

  task automatic test_wrap();
    bit seen;
    fifo_usedw = 9'd64;
    exp_q.push_back({BASE,          4'd8});
    exp_q.push_back({BASE + 32'h20, 4'd4});
    exp_q.push_back({BASE,          4'd4});
    start_xfer(BASE, 32'd16, 32'd12);
    wait_done(120, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL wrap_done: got no done required done"); end
    n_checks++; if (cap_words !== 32'd16) begin n_fail++; $display("FAIL wrap_words: got %0d required 16", cap_words); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_missing: %0d bursts left required 0", exp_q.size()); end
    $display("test_wrap done");
  endtask

  task automatic test_starve_flush();
    bit seen;
    int early;
    fifo_usedw = 9'd3;
    flush      = 1'b0;
    early      = 0;
    start_xfer(BASE, 32'd8, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_start) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL starve_no_start: got %0d starts required 0", early); end
    exp_q.push_back({BASE, 4'd3});
    flush = 1'b1;
    wait_start(10, seen);
    flush      = 1'b0;
    fifo_usedw = 9'd0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL flush_start: got no start required start"); end
    early = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wr_start) early++;
    end
    n_checks++; if (early != 0 || busy !== 1'b1 || words_written !== 32'd3) begin
      n_fail++; $display("FAIL flush_wait: got starts=%0d busy=%b words=%0d required 0 1 3", early, busy, words_written); end
    exp_q.push_back({BASE + 32'hC, 4'd5});
    fifo_usedw = 9'd16;
    wait_done(60, seen);
    n_checks++; if (!seen || cap_words !== 32'd8 || cap_aborted !== 1'b0) begin
      n_fail++; $display("FAIL starve_end: got seen=%b words=%0d aborted=%b required 1 8 0", seen, cap_words, cap_aborted); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL starve_missing: %0d bursts left required 0", exp_q.size()); end
    $display("test_starve_flush done");
  endtask

  task automatic test_stop();
    bit seen;
    fifo_usedw = 9'd64;
    exp_q.push_back({BASE, 4'd8});
    start_xfer(BASE, 32'd32, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_busy) seen = 1'b1;
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(60, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL stop_done: got no done required done"); end
    n_checks++; if (cap_aborted !== 1'b1 || cap_words !== 32'd8) begin
      n_fail++; $display("FAIL stop_status: got aborted=%b words=%0d required 1 8", cap_aborted, cap_words); end
    repeat (3) @(negedge clk);
    n_checks++; if (aborted !== 1'b1) begin n_fail++; $display("FAIL aborted_hold: got %b required 1", aborted); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stop_missing: %0d bursts left required 0", exp_q.size()); end
    $display("test_stop done");
  endtask

  task automatic test_zero_length();
    bit seen;
    start_xfer(BASE, 32'd0, 32'd0);
    wait_done(4, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL zero_done: got no done required done"); end
    n_checks++; if (cap_aborted !== 1'b0 || cap_words !== 32'd0) begin
      n_fail++; $display("FAIL zero_status: got aborted=%b words=%0d required 0 0", cap_aborted, cap_words); end
    $display("test_zero_length done");
  endtask

  task automatic test_reset_mid();
    bit seen;
    fifo_usedw = 9'd64;
    exp_q.push_back({BASE, 4'd8});
    start_xfer(BASE, 32'd32, 32'd0);
    wait_start(10, seen);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if ({wr_start, busy, done, aborted} !== 4'b0000 || wr_baseaddress !== '0 ||
                    wr_burstcount !== '0 || words_written !== '0) begin
      n_fail++; $display("FAIL reset_mid: got start/busy/done/aborted=%b addr=0x%08h count=%0d words=%0d required all 0",
                         {wr_start, busy, done, aborted}, wr_baseaddress, wr_burstcount, words_written); end
    exp_q.push_back({BASE + 32'h100, 4'd8});
    start_xfer(BASE + 32'h100, 32'd8, 32'd0);
    wait_done(60, seen);
    n_checks++; if (!seen || cap_words !== 32'd8) begin
      n_fail++; $display("FAIL restart: got seen=%b words=%0d required 1 8", seen, cap_words); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_missing: %0d bursts left required 0", exp_q.size()); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_split();
    test_wrap();
    test_starve_flush();
    test_stop();
    test_zero_length();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "time limit reached");
  end

endmodule
